// File: rtl/level_sequencer_pkg.sv
// Shared definitions for the symbol-counter game: state encoding and counter widths.
// Pure declarations, no logic and no latency.
// Also imported by the display blocks so that level and countdown widths stay consistent.
package level_sequencer_pkg;

  localparam int STATE_W = 3;
  localparam int LEVEL_W = 4;
  localparam int LIVES_W = 2;
  localparam int SECS_W  = 4;

  // Legacy-compatible state encoding shared with the display blocks.
  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_SHOW   = 3'd1;
  localparam logic [STATE_W-1:0] ST_ANSWER = 3'd2;
  localparam logic [STATE_W-1:0] ST_POST   = 3'd3;
  localparam logic [STATE_W-1:0] ST_OVER   = 3'd4;
  localparam logic [STATE_W-1:0] ST_WON    = 3'd5;

endpackage

// File: rtl/level_sequencer_if.sv
// Bundle between the game sequencer, the button/answer logic and the display blocks.
// Wires only, no latency.
// Pulse-based: every input is a one-cycle event, with no backpressure.
interface level_sequencer_if;
  import level_sequencer_pkg::*;

  logic               startBtn;
  logic               answerValid;
  logic               answerCorrect;
  logic               levelComplete;
  logic               postSig;
  logic               showEn;
  logic               answerEn;
  logic               passed;
  logic [LEVEL_W-1:0] level;
  logic [LIVES_W-1:0] lives;
  logic [SECS_W-1:0]  secsLeft;
  logic               gameOver;
  logic               gameWon;

  // Sequencer side.
  modport slave (
    input  startBtn, answerValid, answerCorrect, levelComplete,
    output postSig, showEn, answerEn, passed, level, lives, secsLeft, gameOver, gameWon
  );

  // Button/answer logic and post-period side.
  modport master (
    output startBtn, answerValid, answerCorrect, levelComplete,
    input  postSig, showEn, answerEn, passed, level, lives, secsLeft, gameOver, gameWon
  );

endinterface

// File: rtl/level_sequencer_tick_sync.sv
// Synchronises the 1 Hz square wave and turns each rising edge into a one-cycle tick.
// Latency: tick is high 3 clk edges after the clkIn rising edge.
// No backpressure; a tick is lost if nobody consumes it that cycle.
module tick_sync (
  input  logic clk,
  input  logic resetN,
  input  logic clkIn,
  output logic tick
);

  logic sync1;
  logic sync2;
  logic sync2Prev;

  // Two-flop synchroniser, previous-value register and registered rising-edge pulse.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync2Prev <= 1'b0;
      tick      <= 1'b0;
    end else begin
      sync1     <= clkIn;
      sync2     <= sync1;
      sync2Prev <= sync2;
      tick      <= sync2 & ~sync2Prev;
    end
  end

endmodule

// File: rtl/level_sequencer.sv
// Game sequencer: steps each level through display, answer entry and result display.
// Latency: every output is registered, and a state change is visible 1 cycle after its trigger.
// No backpressure; inputs that the current state does not use are ignored.
module level_sequencer #(
  parameter int NUM_LEVELS  = 8,
  parameter int SHOW_SECS   = 5,
  parameter int ANSWER_SECS = 10,
  parameter int MAX_LIVES   = 3
) (
  input logic Clk100M,
  input logic Reset_n,
  input logic Clk1Hz,
  level_sequencer_if.slave bus
);
  import level_sequencer_pkg::*;

  logic               tick;
  logic [STATE_W-1:0] stateQ, stateD;
  logic [LEVEL_W-1:0] levelQ, levelD;
  logic [LIVES_W-1:0] livesQ, livesD;
  logic [SECS_W-1:0]  secsQ, secsD;
  logic               passedQ, passedD;
  logic               postSigQ, postSigD;
  logic               showEnQ, answerEnQ, gameOverQ, gameWonQ;
  logic               answerDone, answerFail;

  tick_sync uTickSync (
    .clk   (Clk100M),
    .resetN(Reset_n),
    .clkIn (Clk1Hz),
    .tick  (tick)
  );

  // Next-state and counter updates; an answer outranks a same-cycle timeout tick.
  always_comb begin
    stateD     = stateQ;
    levelD     = levelQ;
    livesD     = livesQ;
    secsD      = secsQ;
    passedD    = passedQ;
    postSigD   = 1'b0;
    answerDone = 1'b0;
    answerFail = 1'b0;
    case (stateQ)
      ST_IDLE, ST_OVER, ST_WON: begin
        if (bus.startBtn) begin
          stateD = ST_SHOW;
          levelD = '0;
          livesD = LIVES_W'(MAX_LIVES);
          secsD  = SECS_W'(SHOW_SECS);
        end
      end
      ST_SHOW: begin
        if (tick) begin
          if (secsQ == SECS_W'(1)) begin
            stateD = ST_ANSWER;
            secsD  = SECS_W'(ANSWER_SECS);
          end else begin
            secsD = secsQ - SECS_W'(1);
          end
        end
      end
      ST_ANSWER: begin
        if (bus.answerValid) begin
          answerDone = 1'b1;
          answerFail = ~bus.answerCorrect;
        end else if (tick) begin
          if (secsQ == SECS_W'(1)) begin
            answerDone = 1'b1;
            answerFail = 1'b1;
          end else begin
            secsD = secsQ - SECS_W'(1);
          end
        end
        if (answerDone) begin
          passedD = ~answerFail;
          secsD   = '0;
          if (answerFail && (livesQ == LIVES_W'(1))) begin
            // Last life gone: the result display is skipped entirely.
            stateD = ST_OVER;
            livesD = '0;
          end else begin
            stateD   = ST_POST;
            postSigD = 1'b1;
            if (answerFail) begin
              livesD = livesQ - LIVES_W'(1);
            end
          end
        end
      end
      ST_POST: begin
        if (bus.levelComplete) begin
          if (passedQ && (levelQ == LEVEL_W'(NUM_LEVELS - 1))) begin
            stateD = ST_WON;
          end else begin
            stateD = ST_SHOW;
            secsD  = SECS_W'(SHOW_SECS);
            if (passedQ) begin
              levelD = levelQ + LEVEL_W'(1);
            end
          end
        end
      end
      default: begin
        // Unreachable encodings recover to IDLE.
        stateD = ST_IDLE;
        secsD  = '0;
      end
    endcase
  end

  // State, counters and phase flags are all registered from the next-state values.
  always_ff @(posedge Clk100M or negedge Reset_n) begin
    if (!Reset_n) begin
      stateQ    <= ST_IDLE;
      levelQ    <= '0;
      livesQ    <= LIVES_W'(MAX_LIVES);
      secsQ     <= '0;
      passedQ   <= 1'b0;
      postSigQ  <= 1'b0;
      showEnQ   <= 1'b0;
      answerEnQ <= 1'b0;
      gameOverQ <= 1'b0;
      gameWonQ  <= 1'b0;
    end else begin
      stateQ    <= stateD;
      levelQ    <= levelD;
      livesQ    <= livesD;
      secsQ     <= secsD;
      passedQ   <= passedD;
      postSigQ  <= postSigD;
      showEnQ   <= (stateD == ST_SHOW);
      answerEnQ <= (stateD == ST_ANSWER);
      gameOverQ <= (stateD == ST_OVER);
      gameWonQ  <= (stateD == ST_WON);
    end
  end

  assign bus.postSig  = postSigQ;
  assign bus.showEn   = showEnQ;
  assign bus.answerEn = answerEnQ;
  assign bus.passed   = passedQ;
  assign bus.level    = levelQ;
  assign bus.lives    = livesQ;
  assign bus.secsLeft = secsQ;
  assign bus.gameOver = gameOverQ;
  assign bus.gameWon  = gameWonQ;

endmodule

// File: tb/tb_level_sequencer.sv
// Bench for level_sequencer: directed scenarios plus a randomized event stream.
// Expected values come from constants and an event-level game model.
// Outputs are sampled 1 time unit after the rising clock edge.
module tb_level_sequencer;

  localparam int NUM_LEVELS  = 8;
  localparam int SHOW_SECS   = 5;
  localparam int ANSWER_SECS = 10;
  localparam int MAX_LIVES   = 3;

  logic Clk100M = 1'b0;
  logic Reset_n = 1'b1;
  logic Clk1Hz  = 1'b0;

  level_sequencer_if bus ();

  level_sequencer #(
    .NUM_LEVELS (NUM_LEVELS),
    .SHOW_SECS  (SHOW_SECS),
    .ANSWER_SECS(ANSWER_SECS),
    .MAX_LIVES  (MAX_LIVES)
  ) dut (
    .Clk100M(Clk100M),
    .Reset_n(Reset_n),
    .Clk1Hz (Clk1Hz),
    .bus    (bus)
  );

  always #5 Clk100M = ~Clk100M;

  int tests = 0;
  int fails = 0;
  int postCount = 0;

  always @(posedge Clk100M) if (bus.postSig === 1'b1) postCount++;

  localparam logic [15:0] RESET_VEC = {4'd0, 2'd3, 4'd0, 6'b000000};

  typedef enum int {M_IDLE, M_SHOW, M_ANSWER, M_POST, M_OVER, M_WON} phase_t;
  phase_t mPhase;
  int mLevel, mLives, mSecs;
  bit mPassed, mPost;

  function automatic logic [15:0] status();
    return {bus.level, bus.lives, bus.secsLeft, bus.showEn, bus.answerEn,
            bus.gameOver, bus.gameWon, bus.postSig, bus.passed};
  endfunction

  task automatic stepCycle();
    @(posedge Clk100M);
    #1;
  endtask

  task automatic pulseStart();
    bus.startBtn = 1'b1; stepCycle(); bus.startBtn = 1'b0;
  endtask

  task automatic pulseAnswer(input logic correct);
    bus.answerValid = 1'b1; bus.answerCorrect = correct;
    stepCycle();
    bus.answerValid = 1'b0; bus.answerCorrect = 1'b0;
  endtask

  task automatic pulseComplete();
    bus.levelComplete = 1'b1; stepCycle(); bus.levelComplete = 1'b0;
  endtask

  // One full 1 Hz period: the tick is consumed on the 4th edge after the rise.
  task automatic oneTick();
    Clk1Hz = 1'b1; repeat (4) stepCycle();
    Clk1Hz = 1'b0; repeat (4) stepCycle();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) oneTick();
  endtask

  // Rise Clk1Hz and land a pulse in the same cycle the tick is consumed (0: correct answer, 1: start).
  task automatic tickWith(input int which);
    Clk1Hz = 1'b1; repeat (3) stepCycle();
    if (which == 0) begin bus.answerValid = 1'b1; bus.answerCorrect = 1'b1; end
    else bus.startBtn = 1'b1;
    stepCycle();
    bus.answerValid = 1'b0; bus.answerCorrect = 1'b0; bus.startBtn = 1'b0;
  endtask

  task automatic settle();
    Clk1Hz = 1'b0; repeat (4) stepCycle();
  endtask

  task automatic test_reset();
    Reset_n = 1'b1; #2 Reset_n = 1'b0;
    repeat (2) stepCycle();
    tests++; if (status() !== RESET_VEC) begin fails++; $display("FAIL reset_state got=%h exp=%h", status(), RESET_VEC); end
    Reset_n = 1'b1;
    stepCycle();
    tests++; if (status() !== RESET_VEC) begin fails++; $display("FAIL idle_after_reset got=%h exp=%h", status(), RESET_VEC); end
  endtask

  task automatic test_show_phase();
    pulseStart();
    tests++; if (bus.showEn !== 1'b1 || bus.secsLeft !== 4'd5 || bus.lives !== 2'd3 || bus.answerEn !== 1'b0)
      begin fails++; $display("FAIL start_show got showEn=%b secs=%0d lives=%0d exp 1/5/3", bus.showEn, bus.secsLeft, bus.lives); end
    ticks(4);
    tests++; if (bus.secsLeft !== 4'd1 || bus.showEn !== 1'b1)
      begin fails++; $display("FAIL show_countdown got secs=%0d showEn=%b exp 1/1", bus.secsLeft, bus.showEn); end
    oneTick();
    tests++; if (bus.answerEn !== 1'b1 || bus.showEn !== 1'b0 || bus.secsLeft !== 4'd10)
      begin fails++; $display("FAIL show_to_answer got answerEn=%b showEn=%b secs=%0d exp 1/0/10", bus.answerEn, bus.showEn, bus.secsLeft); end
  endtask

  task automatic test_correct_answer();
    pulseAnswer(1'b1);
    tests++; if (bus.postSig !== 1'b1 || bus.passed !== 1'b1 || bus.secsLeft !== 4'd0 || bus.answerEn !== 1'b0)
      begin fails++; $display("FAIL correct_post got postSig=%b passed=%b secs=%0d answerEn=%b exp 1/1/0/0", bus.postSig, bus.passed, bus.secsLeft, bus.answerEn); end
    stepCycle();
    tests++; if (bus.postSig !== 1'b0 || bus.showEn !== 1'b0)
      begin fails++; $display("FAIL postsig_width got postSig=%b showEn=%b exp 0/0", bus.postSig, bus.showEn); end
    pulseComplete();
    tests++; if (bus.level !== 4'd1 || bus.showEn !== 1'b1 || bus.secsLeft !== 4'd5)
      begin fails++; $display("FAIL level_advance got level=%0d showEn=%b secs=%0d exp 1/1/5", bus.level, bus.showEn, bus.secsLeft); end
  endtask

  task automatic test_wrong_answer();
    ticks(SHOW_SECS);
    pulseAnswer(1'b0);
    tests++; if (bus.postSig !== 1'b1 || bus.passed !== 1'b0 || bus.lives !== 2'd2)
      begin fails++; $display("FAIL wrong_post got postSig=%b passed=%b lives=%0d exp 1/0/2", bus.postSig, bus.passed, bus.lives); end
    pulseComplete();
    tests++; if (bus.level !== 4'd1 || bus.showEn !== 1'b1 || bus.secsLeft !== 4'd5)
      begin fails++; $display("FAIL replay_level got level=%0d showEn=%b secs=%0d exp 1/1/5", bus.level, bus.showEn, bus.secsLeft); end
  endtask

  task automatic test_timeout_over();
    int p0;
    ticks(SHOW_SECS); pulseAnswer(1'b0); pulseComplete();
    tests++; if (bus.lives !== 2'd1) begin fails++; $display("FAIL last_life got lives=%0d exp 1", bus.lives); end
    ticks(SHOW_SECS); ticks(ANSWER_SECS - 1);
    tests++; if (bus.secsLeft !== 4'd1 || bus.answerEn !== 1'b1)
      begin fails++; $display("FAIL answer_countdown got secs=%0d answerEn=%b exp 1/1", bus.secsLeft, bus.answerEn); end
    p0 = postCount;
    oneTick();
    tests++; if (bus.gameOver !== 1'b1 || bus.lives !== 2'd0 || bus.secsLeft !== 4'd0 || bus.answerEn !== 1'b0)
      begin fails++; $display("FAIL timeout_over got gameOver=%b lives=%0d secs=%0d answerEn=%b exp 1/0/0/0", bus.gameOver, bus.lives, bus.secsLeft, bus.answerEn); end
    tests++; if (postCount !== p0) begin fails++; $display("FAIL over_no_postsig got pulses=%0d exp 0", postCount - p0); end
  endtask

  task automatic test_back_to_back();
    pulseStart();
    tests++; if (bus.level !== 4'd0 || bus.lives !== 2'd3 || bus.gameOver !== 1'b0)
      begin fails++; $display("FAIL restart got level=%0d lives=%0d gameOver=%b exp 0/3/0", bus.level, bus.lives, bus.gameOver); end
    for (int lv = 0; lv < NUM_LEVELS - 1; lv++) begin
      ticks(SHOW_SECS);
      if (lv == 3) begin
        bus.levelComplete = 1'b1;
        pulseAnswer(1'b1);
        tests++; if (bus.postSig !== 1'b1) begin fails++; $display("FAIL early_complete_post got postSig=%b exp 1", bus.postSig); end
        stepCycle();
        bus.levelComplete = 1'b0;
      end else begin
        pulseAnswer(1'b1);
        pulseComplete();
      end
      tests++; if (bus.level !== 4'(lv + 1) || bus.showEn !== 1'b1)
        begin fails++; $display("FAIL chain_level%0d got level=%0d showEn=%b exp %0d/1", lv, bus.level, bus.showEn, lv + 1); end
    end
    oneTick();
    pulseStart();
    tests++; if (bus.secsLeft !== 4'd4 || bus.level !== 4'd7)
      begin fails++; $display("FAIL start_ignored got secs=%0d level=%0d exp 4/7", bus.secsLeft, bus.level); end
    ticks(4); ticks(ANSWER_SECS - 1);
    tickWith(0);
    tests++; if (bus.postSig !== 1'b1 || bus.passed !== 1'b1 || bus.lives !== 2'd3)
      begin fails++; $display("FAIL answer_beats_timeout got postSig=%b passed=%b lives=%0d exp 1/1/3", bus.postSig, bus.passed, bus.lives); end
    settle();
    pulseComplete();
    tests++; if (bus.gameWon !== 1'b1 || bus.level !== 4'd7 || bus.showEn !== 1'b0)
      begin fails++; $display("FAIL game_won got gameWon=%b level=%0d showEn=%b exp 1/7/0", bus.gameWon, bus.level, bus.showEn); end
  endtask

  task automatic test_reset_mid_post();
    pulseStart();
    ticks(SHOW_SECS);
    pulseAnswer(1'b1);
    tests++; if (bus.postSig !== 1'b1) begin fails++; $display("FAIL pre_reset_post got postSig=%b exp 1", bus.postSig); end
    #2 Reset_n = 1'b0;
    #1;
    tests++; if (status() !== RESET_VEC) begin fails++; $display("FAIL async_reset got=%h exp=%h", status(), RESET_VEC); end
    stepCycle();
    Reset_n = 1'b1;
    pulseComplete();
    tests++; if (status() !== RESET_VEC) begin fails++; $display("FAIL complete_in_idle got=%h exp=%h", status(), RESET_VEC); end
    tickWith(1);
    tests++; if (bus.showEn !== 1'b1 || bus.secsLeft !== 4'd5)
      begin fails++; $display("FAIL start_beats_tick got showEn=%b secs=%0d exp 1/5", bus.showEn, bus.secsLeft); end
    settle();
    tests++; if (bus.secsLeft !== 4'd5) begin fails++; $display("FAIL start_tick_dropped got secs=%0d exp 5", bus.secsLeft); end
  endtask

  // Model of the outcome of a finished answer.
  task automatic modelJudge(input bit ok);
    mPassed = ok;
    mSecs   = 0;
    if (!ok && mLives == 1) begin
      mPhase = M_OVER; mLives = 0;
    end else begin
      mPhase = M_POST; mPost = 1'b1;
      if (!ok) mLives = mLives - 1;
    end
  endtask

  task automatic test_random();
    int r;
    bit ok;
    logic [15:0] exp;
    Reset_n = 1'b0; stepCycle(); Reset_n = 1'b1; stepCycle();
    mPhase = M_IDLE; mLevel = 0; mLives = MAX_LIVES; mSecs = 0; mPassed = 1'b0;
    for (int step = 0; step < 400; step++) begin
      mPost = 1'b0;
      r = $urandom_range(0, 99);
      if (r < 55) begin
        oneTick();
        if (mPhase == M_SHOW) begin
          if (mSecs == 1) begin mPhase = M_ANSWER; mSecs = ANSWER_SECS; end
          else mSecs = mSecs - 1;
        end else if (mPhase == M_ANSWER) begin
          if (mSecs == 1) begin modelJudge(1'b0); mPost = 1'b0; end
          else mSecs = mSecs - 1;
        end
      end else if (r < 63) begin
        pulseStart();
        if (mPhase == M_IDLE || mPhase == M_OVER || mPhase == M_WON) begin
          mPhase = M_SHOW; mLevel = 0; mLives = MAX_LIVES; mSecs = SHOW_SECS;
        end
      end else if (r < 83) begin
        ok = ($urandom_range(0, 3) != 0);
        pulseAnswer(ok);
        if (mPhase == M_ANSWER) modelJudge(ok);
      end else begin
        pulseComplete();
        if (mPhase == M_POST) begin
          if (mPassed && mLevel == NUM_LEVELS - 1) mPhase = M_WON;
          else begin
            if (mPassed) mLevel = mLevel + 1;
            mPhase = M_SHOW; mSecs = SHOW_SECS;
          end
        end
      end
      exp = {4'(mLevel), 2'(mLives), 4'(mSecs), mPhase == M_SHOW, mPhase == M_ANSWER,
             mPhase == M_OVER, mPhase == M_WON, mPost, mPassed};
      tests++; if (status() !== exp) begin fails++; $display("FAIL random_step%0d got=%h exp=%h", step, status(), exp); end
    end
  endtask

  initial begin
    bus.startBtn = 1'b0; bus.answerValid = 1'b0; bus.answerCorrect = 1'b0; bus.levelComplete = 1'b0;
    test_reset();
    test_show_phase();
    test_correct_answer();
    test_wrong_answer();
    test_timeout_over();
    test_back_to_back();
    test_reset_mid_post();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
